mc_arbiter: RTL and testbench
=============================

MC_ARBITER -- requirements
Module: mc_arbiter

Interface
REQ-001 Parameter BLK_W, 512, cache-block and memory-port data width in bits.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Parameter STARVE_MAX, 7, number of consecutive grants to other requesters after which a pending DMA request wins.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 dcMiss  in  1  data-cache block read request (level).
REQ-007 dcEvict  in  1  data-cache block write-back request (level).
REQ-008 dcAddr  in  ADDR_W  data-cache request address.
REQ-009 dcBlkOut  in  BLK_W  data-cache eviction data.
REQ-010 icMiss  in  1  instruction-cache block read request (level).
REQ-011 icAddr  in  ADDR_W  instruction-cache request address.
REQ-012 dmaReq, dmaWr  in  1 each  FFT DMA request (level); dmaWr=1 write, 0 read.
REQ-013 dmaAddr  in  ADDR_W  DMA address; dmaBlkOut  in  BLK_W  DMA write data.
REQ-014 memAck  in  1  memory completion pulse; memBlkIn  in  BLK_W  read data, valid when memAck=1.
REQ-015 memReq, memWr  out  1 each  memory request and direction.
REQ-016 memAddr  out  ADDR_W  block-aligned address; memBlkOut  out  BLK_W  write data.
REQ-017 mcDataIn  out  BLK_W  registered read data, broadcast to all requesters.
REQ-018 mcDataValid, evictDone, icDataValid, dmaDone  out  1 each  one-cycle completion pulses.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 States SHALL be IDLE, ISSUE, RESP; encoding is implementation choice.
REQ-021 IDLE: with any request high, the arbiter SHALL latch winner, direction, address and write data and go to ISSUE next cycle; otherwise stay IDLE.
REQ-022 Priority: dcEvict > dcMiss > icMiss > dmaReq, except when dmaReq=1 and starveCnt=STARVE_MAX, in which case DMA SHALL win.
REQ-023 dcEvict and dcMiss both high SHALL grant the eviction (write) first.
REQ-024 ISSUE: memReq=1 with memWr, memAddr, memBlkOut held constant from latched values until memAck=1.
REQ-025 memAddr SHALL be latched address with bits [5:0] forced to 0.
REQ-026 memAck in ISSUE: capture memBlkIn into mcDataIn on reads (unchanged on writes), drop memReq the next cycle, go to RESP.
REQ-027 RESP: pulse exactly one completion output for one cycle -- dcache write evictDone, dcache read mcDataValid, icache icDataValid, DMA dmaDone -- then go to IDLE.
REQ-028 Minimum turnaround with memAck in the first ISSUE cycle: request at cycle N, memReq N+1, done pulse N+2, next arbitration N+3.
REQ-029 Requesters SHALL drop or change their request the cycle after their done pulse; the arbiter SHALL re-sample in IDLE only.
REQ-030 Requests arriving or dropping while busy SHALL be ignored until the next IDLE; the latched transaction SHALL complete unchanged.
REQ-031 memAck outside ISSUE SHALL be ignored.
REQ-032 starveCnt (width clog2(STARVE_MAX+1)) SHALL increment on each non-DMA grant while dmaReq=1, saturate at STARVE_MAX, clear on a DMA grant or any IDLE cycle with dmaReq=0.
REQ-033 mcDataIn SHALL hold its value until the next read capture.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, memReq=0, memWr=0, memAddr=0, memBlkOut=0, mcDataIn=0, all done pulses 0, busy=0, starveCnt=0.
REQ-035 Reset mid-ISSUE SHALL abandon the transaction with no done pulse; a later memAck SHALL be ignored.
REQ-036 Arbitration SHALL resume at the first rising edge after rst_n rises.

Verification
REQ-037 dcMiss=1, dcAddr=0x1000_0047, memAck after 3 cycles with 0xA5 pattern -> memAddr=0x1000_0040, memWr=0, mcDataValid one cycle, mcDataIn=0xA5 pattern.
REQ-038 dcEvict and dcMiss together -> write granted first, evictDone; then read, mcDataValid; no overlap.
REQ-039 icMiss and dmaReq together with dcMiss held -> order dcache, icache, DMA; memReq never overlaps.
REQ-040 dmaReq held, dcMiss reasserted after every completion -> DMA granted on the 8th arbitration; starveCnt then 0.
REQ-041 rst_n low during ISSUE, memAck pulsed 2 cycles later -> memReq=0 at once, no done pulse, state IDLE.
REQ-042 Stray memAck in IDLE -> no state change, no pulse, mcDataIn unchanged.

Source files
------------

// File: rtl/mc_arbiter.sv
// mc_arbiter: single-port memory arbiter for dcache, icache and FFT DMA block transfers.
// DMA is protected from starvation by a saturating count of grants it has lost.
module mc_arbiter #(
    parameter int BLK_W      = 512,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dcMiss,
    input  logic              dcEvict,
    input  logic [ADDR_W-1:0] dcAddr,
    input  logic [BLK_W-1:0]  dcBlkOut,
    input  logic              icMiss,
    input  logic [ADDR_W-1:0] icAddr,
    input  logic              dmaReq,
    input  logic              dmaWr,
    input  logic [ADDR_W-1:0] dmaAddr,
    input  logic [BLK_W-1:0]  dmaBlkOut,
    input  logic              memAck,
    input  logic [BLK_W-1:0]  memBlkIn,
    output logic              memReq,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [BLK_W-1:0]  memBlkOut,
    output logic [BLK_W-1:0]  mcDataIn,
    output logic              mcDataValid,
    output logic              evictDone,
    output logic              icDataValid,
    output logic              dmaDone,
    output logic              busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic [1:0] {DC_RD, DC_WR, IC_RD, DMA} owner_t;

    state_t            state, nextState;
    owner_t            owner, grant;
    logic [CW-1:0]     starveCnt;
    logic [ADDR_W-1:0] addrQ;
    logic              anyReq, grantWr;
    logic [ADDR_W-1:0] grantAddr;
    logic [BLK_W-1:0]  grantBlk;

    always_comb begin
        anyReq    = dcEvict | dcMiss | icMiss | dmaReq;
        grant     = (dmaReq && starveCnt == SMAX) ? DMA :
                    dcEvict ? DC_WR : dcMiss ? DC_RD : icMiss ? IC_RD : DMA;
        grantWr   = grant == DC_WR || (grant == DMA && dmaWr);
        grantAddr = grant == DMA ? dmaAddr : grant == IC_RD ? icAddr : dcAddr;
        grantBlk  = grant == DMA ? dmaBlkOut : dcBlkOut;
        nextState = state == IDLE  ? (anyReq ? ISSUE : IDLE) :
                    state == ISSUE ? (memAck ? RESP : ISSUE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= DC_RD;
            memWr     <= 1'b0;
            addrQ     <= '0;
            memBlkOut <= '0;
            mcDataIn  <= '0;
            starveCnt <= '0;
        end else begin
            if (state == IDLE && anyReq) begin
                owner     <= grant;
                memWr     <= grantWr;
                addrQ     <= grantAddr;
                memBlkOut <= grantBlk;
            end
            if (state == ISSUE && memAck && !memWr) mcDataIn <= memBlkIn;
            // count only grants DMA actually lost while it was asking
            if (state == IDLE) begin
                if (!dmaReq)             starveCnt <= '0;
                else if (grant == DMA)   starveCnt <= '0;
                else if (starveCnt != SMAX) starveCnt <= starveCnt + CW'(1);
            end
        end
    end

    assign memReq      = state == ISSUE;
    assign busy        = state != IDLE;
    assign memAddr     = addrQ & ~ADDR_W'(6'h3f);
    assign mcDataValid = state == RESP && owner == DC_RD;
    assign evictDone   = state == RESP && owner == DC_WR;
    assign icDataValid = state == RESP && owner == IC_RD;
    assign dmaDone     = state == RESP && owner == DMA;
endmodule

// File: tb/tb_mc_arbiter.sv
// tb_mc_arbiter: scoreboard bench; expected grants are queued as requests are driven
// and popped when the arbiter issues each memory request.
module tb_mc_arbiter;
    localparam int BLK_W  = 512;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              dcMiss = 0, dcEvict = 0, icMiss = 0, dmaReq = 0, dmaWr = 0, memAck = 0;
    logic [ADDR_W-1:0] dcAddr = '0, icAddr = '0, dmaAddr = '0;
    logic [BLK_W-1:0]  dcBlkOut = '0, dmaBlkOut = '0, memBlkIn = '0;
    logic              memReq, memWr, mcDataValid, evictDone, icDataValid, dmaDone, busy;
    logic [ADDR_W-1:0] memAddr;
    logic [BLK_W-1:0]  memBlkOut, mcDataIn;
    logic [3:0]        dones;

    typedef struct packed {
        logic [3:0]        done;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BLK_W-1:0]  wdata;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0, errors = 0;
    logic [BLK_W-1:0] lastRd = '0;

    localparam logic [3:0] D_RD = 4'b1000, D_WR = 4'b0100, D_IC = 4'b0010, D_DMA = 4'b0001;

    mc_arbiter dut (
        .clk(clk), .rst_n(rst_n), .dcMiss(dcMiss), .dcEvict(dcEvict), .dcAddr(dcAddr),
        .dcBlkOut(dcBlkOut), .icMiss(icMiss), .icAddr(icAddr), .dmaReq(dmaReq), .dmaWr(dmaWr),
        .dmaAddr(dmaAddr), .dmaBlkOut(dmaBlkOut), .memAck(memAck), .memBlkIn(memBlkIn),
        .memReq(memReq), .memWr(memWr), .memAddr(memAddr), .memBlkOut(memBlkOut),
        .mcDataIn(mcDataIn), .mcDataValid(mcDataValid), .evictDone(evictDone),
        .icDataValid(icDataValid), .dmaDone(dmaDone), .busy(busy)
    );

    assign dones = {mcDataValid, evictDone, icDataValid, dmaDone};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_txn(input logic [3:0] d, input logic w,
                                       input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] wd);
        exp_t e;
        e.done  = d;
        e.wr    = w;
        e.addr  = a & 32'hFFFF_FFC0;
        e.wdata = wd;
        sb.push_back(e);
    endfunction

    task automatic serve(input int dly, input logic [BLK_W-1:0] rdata);
        exp_t e;
        int   n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL turnaround cycles_to_memReq=%0d required 1", n);
        end
        if (!memReq) return;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard unexpected request addr=%h wr=%b", memAddr, memWr);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (memAddr !== e.addr || memWr !== e.wr || (e.wr && memBlkOut !== e.wdata)) begin
            errors++;
            $display("FAIL issue addr=%h wr=%b data_ok=%b required addr=%h wr=%b",
                     memAddr, memWr, memBlkOut === e.wdata, e.addr, e.wr);
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            checks++;
            if (memReq !== 1'b1 || dones !== 4'b0 || memAddr !== e.addr || memWr !== e.wr) begin
                errors++;
                $display("FAIL issue_hold memReq=%b dones=%b addr=%h required 1 0000 %h",
                         memReq, dones, memAddr, e.addr);
            end
        end
        memAck   = 1'b1;
        memBlkIn = rdata;
        tick();
        memAck   = 1'b0;
        memBlkIn = '0;
        checks++;
        if (dones !== e.done || memReq !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse dones=%b memReq=%b busy=%b required %b 0 1",
                     dones, memReq, busy, e.done);
        end
        if (!e.wr) lastRd = rdata;
        checks++;
        if (mcDataIn !== lastRd) begin
            errors++;
            $display("FAIL mcDataIn got=%h required=%h", mcDataIn[63:0], lastRd[63:0]);
        end
        tick();
        checks++;
        if (dones !== 4'b0 || busy !== 1'b0 || memReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_return dones=%b busy=%b memReq=%b required 0000 0 0",
                     dones, busy, memReq);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (memReq !== 0 || memWr !== 0 || memAddr !== '0 || memBlkOut !== '0 ||
            mcDataIn !== '0 || dones !== 4'b0 || busy !== 0) begin
            errors++;
            $display("FAIL reset memReq=%b memWr=%b memAddr=%h dones=%b busy=%b required all 0",
                     memReq, memWr, memAddr, dones, busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        dcMiss = 1'b1;
        dcAddr = 32'h1000_0047;
        expect_txn(D_RD, 1'b0, dcAddr, '0);
        serve(3, {64{8'hA5}});
        dcMiss = 1'b0;
    endtask

    task automatic test_evict_miss();
        dcEvict  = 1'b1;
        dcMiss   = 1'b1;
        dcAddr   = 32'h2000_0085;
        dcBlkOut = {16{32'hDEAD_BEEF}};
        expect_txn(D_WR, 1'b1, dcAddr, dcBlkOut);
        expect_txn(D_RD, 1'b0, dcAddr, '0);
        serve(0, {64{8'h11}});
        dcEvict = 1'b0;
        serve(1, {64{8'h3C}});
        dcMiss = 1'b0;
    endtask

    task automatic test_stray_ack();
        memAck   = 1'b1;
        memBlkIn = ~lastRd;
        tick();
        memAck   = 1'b0;
        memBlkIn = '0;
        checks++;
        if (busy !== 0 || memReq !== 0 || dones !== 4'b0 || mcDataIn !== lastRd) begin
            errors++;
            $display("FAIL stray_ack busy=%b memReq=%b dones=%b data_ok=%b required 0 0 0000 1",
                     busy, memReq, dones, mcDataIn === lastRd);
        end
        tick();
    endtask

    task automatic test_order();
        dcMiss  = 1'b1;
        icMiss  = 1'b1;
        dmaReq  = 1'b1;
        dmaWr   = 1'b0;
        dcAddr  = 32'h3000_0010;
        icAddr  = 32'h0040_00FF;
        dmaAddr = 32'h8000_1234;
        expect_txn(D_RD, 1'b0, dcAddr, '0);
        expect_txn(D_IC, 1'b0, icAddr, '0);
        expect_txn(D_DMA, 1'b0, dmaAddr, '0);
        serve(0, {64{8'h01}});
        dcMiss = 1'b0;
        serve(1, {64{8'h02}});
        icMiss = 1'b0;
        serve(2, {64{8'h03}});
        dmaReq = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        dcMiss    = 1'b1;
        dmaReq    = 1'b1;
        dmaWr     = 1'b1;
        dcAddr    = 32'h4000_0100;
        dmaAddr   = 32'h9000_0077;
        dmaBlkOut = {8{64'h0123_4567_89AB_CDEF}};
        for (int i = 0; i < 7; i++) expect_txn(D_RD, 1'b0, dcAddr, '0);
        expect_txn(D_DMA, 1'b1, dmaAddr, dmaBlkOut);
        for (int i = 0; i < 8; i++) serve(0, {64{8'(8'h40 + i)}});
        // counter must be clear after the DMA grant, so dcache wins again
        expect_txn(D_RD, 1'b0, dcAddr, '0);
        serve(0, {64{8'h5A}});
        dcMiss = 1'b0;
        expect_txn(D_DMA, 1'b1, dmaAddr, dmaBlkOut);
        serve(0, '0);
        dmaReq = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dcMiss = 1'b1;
        dcAddr = 32'h5000_0200;
        tick();
        checks++;
        if (memReq !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue memReq=%b required 1", memReq);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (memReq !== 0 || busy !== 0 || memWr !== 0 || memAddr !== '0 || mcDataIn !== '0 ||
            dones !== 4'b0) begin
            errors++;
            $display("FAIL async_reset memReq=%b busy=%b memAddr=%h dones=%b required 0 0 0 0000",
                     memReq, busy, memAddr, dones);
        end
        dcMiss = 1'b0;
        lastRd = '0;
        tick();
        rst_n = 1'b1;
        tick();
        memAck   = 1'b1;
        memBlkIn = {64{8'hEE}};
        tick();
        memAck   = 1'b0;
        memBlkIn = '0;
        checks++;
        if (busy !== 0 || dones !== 4'b0 || mcDataIn !== '0) begin
            errors++;
            $display("FAIL late_ack busy=%b dones=%b required 0 0000", busy, dones);
        end
        tick();
        checks++;
        if (dones !== 4'b0 || busy !== 0) begin
            errors++;
            $display("FAIL late_ack_after dones=%b busy=%b required 0000 0", dones, busy);
        end
        icMiss = 1'b1;
        icAddr = 32'h0000_1FC1;
        expect_txn(D_IC, 1'b0, icAddr, '0);
        serve(0, {64{8'h77}});
        icMiss = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_evict_miss();
        test_stray_ack();
        test_order();
        test_starve();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
